// File: rtl/memory_access_pkg.sv
// Shared types and helpers for memory_access_controller.
//   refresh_state_t     : DRAM refresh FSM encoding
//   REFRESH_COUNT_WIDTH : width of the completed-refresh counter
//   rom_init_word()     : ROM power-up contents, word i = i*3 truncated to width
package memory_access_pkg;

    typedef enum logic {NORMAL, REFRESH} refresh_state_t;

    localparam int REFRESH_COUNT_WIDTH = 16;

    function automatic logic [63:0] rom_init_word(input int i, input int width);
        logic [63:0] w;
        w = 64'(i * 3);
        if (width < 64) begin
            w = w & ((64'd1 << width) - 64'd1);
        end
        return w;
    endfunction

endpackage

// File: rtl/mac_rsp_pipeline.sv
// Fixed-latency response pipeline: a LATENCY-deep shift register of
// {valid, data, err}. Synchronous active-high reset flushes every stage.
// Ports:
//   clk, reset            : clock / synchronous active-high reset
//   in_valid_i/data/err   : response launched on the accept edge
//   out_valid_o/data/err  : response LATENCY cycles later
module mac_rsp_pipeline #(
    parameter int LATENCY    = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_err_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_err_o
);

    logic                  valid_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_q  [LATENCY];
    logic                  err_q   [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= '0;
                err_q[i]   <= 1'b0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            data_q[0]  <= in_data_i;
            err_q[0]   <= in_err_i;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
        end
    end

    assign out_valid_o = valid_q[LATENCY-1];
    assign out_data_o  = data_q[LATENCY-1];
    assign out_err_o   = err_q[LATENCY-1];

endmodule

// File: rtl/memory_access_controller.sv
// Typed memory (SRAM / DRAM / ROM) behind a valid/ready request port with a
// fixed READ_LATENCY response pipeline. DRAM adds a refresh FSM that stalls
// requests. Optional macro MEMCTL_PARITY_EN adds a stored even-parity bit
// per word (parity_inject flips it on the accepted write).
// Ports:
//   clk, reset                 : clock / synchronous active-high reset
//   req_valid/ready/write/addr/wdata : request handshake
//   rsp_valid/data/err         : one-cycle response pulse
//   refresh_active, refresh_count : DRAM refresh status
//   parity_inject              : corrupt parity of the accepted write
//
// DRAM refresh FSM
//   state   | meaning
//   NORMAL  | accepting requests, interval counter running
//   REFRESH | req_ready low for REFRESH_CYCLES cycles
module memory_access_controller
    import memory_access_pkg::*;
#(
    parameter string MEMORY_TYPE      = "SRAM",
    parameter int    DATA_WIDTH       = 8,
    parameter int    ADDR_WIDTH       = 4,
    parameter int    READ_LATENCY     = 1,
    parameter int    REFRESH_INTERVAL = 32,
    parameter int    REFRESH_CYCLES   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_write,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    output logic                           rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic                           refresh_active,
    output logic [REFRESH_COUNT_WIDTH-1:0] refresh_count,
    input  logic                           parity_inject
);

    localparam int DEPTH   = 2 ** ADDR_WIDTH;
    localparam bit IS_SRAM = (MEMORY_TYPE == "SRAM");
    localparam bit IS_DRAM = (MEMORY_TYPE == "DRAM");
    localparam bit IS_ROM  = (MEMORY_TYPE == "ROM");

    if (!(IS_SRAM || IS_DRAM || IS_ROM)) begin : g_bad_type
        $fatal(1, "memory_access_controller: MEMORY_TYPE must be SRAM, DRAM or ROM");
    end
    if (DATA_WIDTH < 1 || DATA_WIDTH > 64 || READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_size
        $fatal(1, "memory_access_controller: DATA_WIDTH or READ_LATENCY out of range");
    end

    logic                  in_refresh;
    logic                  accept;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_par_err;
    logic                  unused_sink;

    // In ROM builds wdata is dead, and without parity the inject pin is dead.
    assign unused_sink = ^{req_wdata, parity_inject};

    // Ready is combinational on reset so it rises in the first cycle after release.
    assign req_ready = !reset && !in_refresh;
    assign accept    = req_valid && req_ready;

    if (IS_ROM) begin : g_rom
        assign rd_word    = DATA_WIDTH'(rom_init_word(int'(req_addr), DATA_WIDTH));
        // ROM parity comes from the same init word, so it can never disagree.
        assign rd_par_err = 1'b0;
    end else begin : g_ram
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`ifdef MEMCTL_PARITY_EN
        logic par_q [DEPTH];
`endif
        // Storage is deliberately not reset: contents survive reset.
        always_ff @(posedge clk) begin
            if (accept && req_write) begin
                mem_q[req_addr] <= req_wdata;
`ifdef MEMCTL_PARITY_EN
                par_q[req_addr] <= (^req_wdata) ^ parity_inject;
`endif
            end
        end
        assign rd_word = mem_q[req_addr];
`ifdef MEMCTL_PARITY_EN
        assign rd_par_err = (^rd_word) != par_q[req_addr];
`else
        assign rd_par_err = 1'b0;
`endif
    end

    if (IS_DRAM) begin : g_dram
        localparam int CNT_MAX = (REFRESH_INTERVAL > REFRESH_CYCLES) ? REFRESH_INTERVAL
                                                                     : REFRESH_CYCLES;
        localparam int CNT_W   = $clog2(CNT_MAX);

        refresh_state_t                   state_q, state_d;
        logic [CNT_W-1:0]                 cnt_q, cnt_d;
        logic [REFRESH_COUNT_WIDTH-1:0]   rcount_q, rcount_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q  <= NORMAL;
                cnt_q    <= '0;
                rcount_q <= '0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                rcount_q <= rcount_d;
            end
        end

        // One counter serves both states: interval length in NORMAL,
        // refresh duration in REFRESH.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q + CNT_W'(1);
            rcount_d = rcount_q;
            case (state_q)
                NORMAL: begin
                    if (cnt_q == CNT_W'(REFRESH_INTERVAL - 1)) begin
                        state_d = REFRESH;
                        cnt_d   = '0;
                    end
                end
                REFRESH: begin
                    if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
                        state_d  = NORMAL;
                        cnt_d    = '0;
                        rcount_d = rcount_q + REFRESH_COUNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            endcase
        end

        assign in_refresh    = (state_q == REFRESH);
        assign refresh_count = rcount_q;
    end else begin : g_no_refresh
        assign in_refresh    = 1'b0;
        assign refresh_count = '0;
    end

    assign refresh_active = in_refresh;

    logic [DATA_WIDTH-1:0] pipe_data;
    logic                  pipe_err;

    // Writes respond with zero data; only ROM writes and bad parity flag errors.
    assign pipe_data = (accept && !req_write) ? rd_word : '0;
    assign pipe_err  = accept && (req_write ? IS_ROM : rd_par_err);

    mac_rsp_pipeline #(
        .LATENCY    (READ_LATENCY),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_pipeline (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (accept),
        .in_data_i   (pipe_data),
        .in_err_i    (pipe_err),
        .out_valid_o (rsp_valid),
        .out_data_o  (rsp_data),
        .out_err_o   (rsp_err)
    );

endmodule

// File: tb/tb_memory_access_controller.sv
// Three controllers share clock, reset and request fields; each has its own
// req_valid. Index 0 = SRAM (latency 2), 1 = ROM (latency 4),
// 2 = DRAM (latency 1, interval 8, refresh 3).
module tb_memory_access_controller;

`ifdef MEMCTL_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif
    localparam int IVL    = 8;
    localparam int RCY    = 3;
    localparam int PERIOD = IVL + RCY;
    localparam int MAXC   = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       v_sram, v_rom, v_dram;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       inject;

    logic [2:0] o_ready, o_rv, o_re, o_ra;
    logic [7:0] o_rd [3];
    logic [15:0] o_rc [3];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t     = 0;

    bit         ev [3][MAXC];
    bit         ek [3][MAXC];
    logic [7:0] ed [3][MAXC];
    bit         ee [3][MAXC];
    logic [7:0] mem_m   [3][16];
    bit         known_m [3][16];
    bit         bad_m   [3][16];

    always #5 clk = ~clk;

    memory_access_controller #(.MEMORY_TYPE("SRAM"), .READ_LATENCY(2)) u_sram (
        .clk(clk), .reset(rst), .req_valid(v_sram), .req_ready(o_ready[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(o_rv[0]), .rsp_data(o_rd[0]), .rsp_err(o_re[0]),
        .refresh_active(o_ra[0]), .refresh_count(o_rc[0]), .parity_inject(inject));

    memory_access_controller #(.MEMORY_TYPE("ROM"), .READ_LATENCY(4)) u_rom (
        .clk(clk), .reset(rst), .req_valid(v_rom), .req_ready(o_ready[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(o_rv[1]), .rsp_data(o_rd[1]), .rsp_err(o_re[1]),
        .refresh_active(o_ra[1]), .refresh_count(o_rc[1]), .parity_inject(inject));

    memory_access_controller #(.MEMORY_TYPE("DRAM"), .READ_LATENCY(1),
                               .REFRESH_INTERVAL(IVL), .REFRESH_CYCLES(RCY)) u_dram (
        .clk(clk), .reset(rst), .req_valid(v_dram), .req_ready(o_ready[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(o_rv[2]), .rsp_data(o_rd[2]), .rsp_err(o_re[2]),
        .refresh_active(o_ra[2]), .refresh_count(o_rc[2]), .parity_inject(inject));

    function automatic int lat_of(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check this cycle's outputs against the model, advance the model.
    task automatic step();
        logic vk;
        bit   rdy;
        int   due;
        int   a;
        @(negedge clk);
        a = int'(req_addr);
        for (int k = 0; k < 3; k++) begin
            vk = (k == 0) ? v_sram : (k == 1) ? v_rom : v_dram;
            if (rst) begin
                chk($sformatf("ready_in_reset%0d", k), o_ready[k], 0);
            end else begin
                // DRAM: each period is IVL ready cycles then RCY refresh cycles.
                rdy = (k != 2) || ((t % PERIOD) < IVL);
                chk($sformatf("ready%0d", k), o_ready[k], rdy);
                chk($sformatf("refresh_active%0d", k), o_ra[k], !rdy);
                chk($sformatf("refresh_count%0d", k), o_rc[k], (k == 2) ? (t / PERIOD) : 0);
                if (ev[k][cyc]) begin
                    chk($sformatf("rsp_valid%0d", k), o_rv[k], 1);
                    if (ek[k][cyc]) begin
                        chk($sformatf("rsp_data%0d", k), o_rd[k], ed[k][cyc]);
                        chk($sformatf("rsp_err%0d", k), o_re[k], ee[k][cyc]);
                    end
                end else begin
                    chk($sformatf("rsp_idle%0d", k), o_rv[k], 0);
                end
                if (vk && rdy) begin
                    due = cyc + lat_of(k);
                    ev[k][due] = 1'b1;
                    if (req_write) begin
                        ed[k][due] = 8'h00;
                        ek[k][due] = 1'b1;
                        ee[k][due] = (k == 1);
                        if (k != 1) begin
                            mem_m[k][a]   = req_wdata;
                            known_m[k][a] = 1'b1;
                            bad_m[k][a]   = inject;
                        end
                    end else if (k == 1) begin
                        ed[k][due] = 8'((a * 3) % 256);
                        ek[k][due] = 1'b1;
                        ee[k][due] = 1'b0;
                    end else begin
                        ed[k][due] = mem_m[k][a];
                        ek[k][due] = known_m[k][a];
                        ee[k][due] = PARITY_ON && bad_m[k][a];
                    end
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            t = 0;
            for (int k = 0; k < 3; k++)
                for (int d = cyc + 1; d <= cyc + 5; d++) ev[k][d] = 1'b0;
        end else begin
            t++;
        end
        cyc++;
        #1;
    endtask

    task automatic req(input logic vs, input logic vr, input logic vd, input logic wr,
                       input logic [3:0] ad, input logic [7:0] wd, input logic inj);
        v_sram = vs; v_rom = vr; v_dram = vd;
        req_write = wr; req_addr = ad; req_wdata = wd; inject = inj;
        step();
    endtask

    initial begin
        rst = 1'b1;
        req(0, 0, 0, 0, 4'd0, 8'h00, 0);
        req(0, 0, 0, 0, 4'd0, 8'h00, 0);
        rst = 1'b0;

        // SRAM write then immediate read of the same address.
        req(1, 0, 0, 1, 4'd3, 8'hA5, 0);
        req(1, 0, 0, 0, 4'd3, 8'h00, 0);
        repeat (3) req(0, 0, 0, 0, 4'd0, 8'h00, 0);

        // ROM read / illegal write / re-read.
        req(0, 1, 0, 0, 4'd5, 8'h00, 0);
        req(0, 1, 0, 1, 4'd5, 8'hFF, 0);
        req(0, 1, 0, 0, 4'd5, 8'h00, 0);

        // ROM back-to-back reads over the whole array.
        for (int i = 0; i < 16; i++) req(0, 1, 0, 0, 4'(i), 8'h00, 0);
        repeat (5) req(0, 0, 0, 0, 4'd0, 8'h00, 0);

        // DRAM with valid held high across two refreshes, from a fresh reset.
        rst = 1'b1;
        req(0, 0, 0, 0, 4'd0, 8'h00, 0);
        rst = 1'b0;
        for (int i = 0; i < 2 * PERIOD + 4; i++) req(0, 0, 1, i[0], 4'(i), 8'(i * 7), 0);

        // Parity corruption and repair on the SRAM.
        req(1, 0, 0, 1, 4'd7, 8'h3C, 1);
        req(1, 0, 0, 0, 4'd7, 8'h00, 0);
        req(1, 0, 0, 1, 4'd7, 8'h3C, 0);
        req(1, 0, 0, 0, 4'd7, 8'h00, 0);
        repeat (3) req(0, 0, 0, 0, 4'd0, 8'h00, 0);

        // Randomised traffic on all three controllers.
        for (int i = 0; i < 1500; i++)
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 8'($urandom),
                $urandom_range(0, 7) == 0);
        repeat (5) req(0, 0, 0, 0, 4'd0, 8'h00, 0);

        // Reset in the middle of the first refresh with ROM reads in flight.
        rst = 1'b1;
        req(0, 0, 0, 0, 4'd0, 8'h00, 0);
        rst = 1'b0;
        for (int n = 0; n < 40 && (t % PERIOD) != IVL + 1; n++)
            req(0, 1, 1, 0, 4'(n), 8'h00, 0);
        chk("reach_mid_refresh", t % PERIOD, IVL + 1);
        req(0, 1, 1, 0, 4'd2, 8'h00, 0);
        rst = 1'b1;
        req(0, 0, 0, 0, 4'd0, 8'h00, 0);
        req(0, 0, 0, 0, 4'd0, 8'h00, 0);
        rst = 1'b0;
        repeat (8) req(0, 0, 0, 0, 4'd0, 8'h00, 0);
        req(0, 0, 1, 0, 4'd3, 8'h00, 0);
        repeat (3) req(0, 0, 0, 0, 4'd0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
